operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, immediates and operands.
REQ-002 SHALL have parameter CTRL_W, default 16, width of the opaque decoded-control bundle.
REQ-003 SHALL have the following ports, one per line.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc, in_imm  in  XLEN  instruction PC and immediate
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  5  source and destination register indices
- in_rd_we, in_is_load  in  1  instruction writes rd; instruction is a load
- in_ctrl  in  CTRL_W  decoded control, passed through unchanged
- rf_rs1_addr, rf_rs2_addr  out  5  register-file read addresses, combinationally equal to in_rs1_addr and in_rs2_addr
- rf_rs1_data, rf_rs2_data  in  XLEN  asynchronous register-file read data; x0 reads as 0
- mem_valid, mem_rd_we, mem_is_load  in  1  EX/MEM register status
- mem_rd_addr  in  5  EX/MEM destination index
- mem_result  in  XLEN  EX/MEM ALU result
- wb_we  in  1  register-file write enable this cycle
- wb_rd_addr  in  5  register-file write index
- wb_data  in  XLEN  register-file write data
- flush  in  1  discard held and incoming instructions
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute consumes out_* this cycle
- out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN  registered PC, immediate and resolved operands
- out_rd_addr  out  5  registered destination index
- out_rd_we, out_is_load  out  1  registered destination write enable and load flag
- out_ctrl  out  CTRL_W  registered control bundle
- stall_count  out  16  saturating count of load-use stall cycles

Function
REQ-004 SHALL compute operand N (rs1 or rs2) by this priority: 0 if addr==0; mem_result if mem_valid && mem_rd_we && !mem_is_load && mem_rd_addr==addr; wb_data if wb_we && wb_rd_addr==addr; otherwise rf data.
REQ-005 SHALL define the match for source N as: in_valid && addrN!=0.
REQ-006 SHALL assert hazard when a source matches either of two producers: a held load (out_valid && out_is_load && out_rd_we && out_rd_addr==addrN) or an EX/MEM load (mem_valid && mem_is_load && mem_rd_we && mem_rd_addr==addrN).
REQ-007 SHALL drive in_ready = !reset && !flush && !hazard && (!out_valid || out_ready), purely combinationally.
REQ-008 SHALL, on accept (in_valid && in_ready), load all out_* registers from in_* and the resolved operands, and set out_valid=1; latency is 1 cycle.
REQ-009 SHALL, when not accepting and out_ready==1, clear out_valid, inserting a bubble; all other out_* fields remain unchanged.
REQ-010 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-011 SHALL, on flush, clear out_valid the next cycle regardless of other inputs and accept nothing.
REQ-012 SHALL increment stall_count each cycle in which in_valid && hazard && !flush, and saturate at 16'hFFFF.
REQ-013 SHALL make a load produce a stall of at most two consecutive cycles: one while the load is held here and one while it sits in EX/MEM, after which wb forwarding supplies its data.
REQ-014 SHALL forward a same-cycle register-file write (wb) even when rd_addr equals the read address, because the register file updates only at the clock edge.

Reset
REQ-015 SHALL, in any cycle where reset is high, clear out_valid, all out_* data fields and stall_count to 0 on the next edge, and hold in_ready=0.
REQ-016 SHALL have reset override flush, accept and hold; an instruction mid-stall during reset is dropped.

Verification
REQ-017 SHALL cover: rf x5=0x11, mem writes x5=0x22 (ALU), wb writes x5=0x33; issue add rs1=x5 -> out_rs1_val=0x22; remove mem -> 0x33; remove wb too -> 0x11.
REQ-018 SHALL cover: rs1=x0 with mem_rd_addr=0 and mem_result=0xDEAD -> out_rs1_val=0.
REQ-019 SHALL cover: lw x7, then add rs2=x7 with out_ready=1 -> in_ready=0 for 2 cycles, two bubbles, stall_count=2; third cycle, with wb_data=0xBEEF -> out_rs2_val=0xBEEF.
REQ-020 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_* constant, in_ready=0; out_ready=1 -> next instruction loaded the following cycle.
REQ-021 SHALL cover: flush during a load-use stall -> out_valid=0 next cycle, no accept, stall_count unchanged in the flush cycle.
REQ-022 SHALL cover: reset asserted with out_valid=1 and stall_count=9 -> out_valid=0, stall_count=0, and in_ready=0 while reset is high.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: resolves rs1/rs2 with mem/wb forwarding,
// stalls on load-use, and holds the ID/EX register under handshake.
// Ports:
//   clk, reset                  sync active-high reset
//   in_valid/in_ready, in_*     instruction from decode
//   rf_rs*_addr/rf_rs*_data     async register-file read port
//   mem_*                       EX/MEM producer status and ALU result
//   wb_*                        register-file write this cycle
//   flush                       drop held and incoming instruction
//   out_valid/out_ready, out_*  ID/EX register to execute
//   stall_count                 saturating load-use stall counter
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [4:0]        in_rs1_addr,
  input  logic [4:0]        in_rs2_addr,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_rs1_addr,
  output logic [4:0]        rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              mem_valid,
  input  logic              mem_rd_we,
  input  logic              mem_is_load,
  input  logic [4:0]        mem_rd_addr,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rd_addr,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_count
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            m1;
  logic            m2;
  logic            hazard;
  logic            accept;

  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;

  // Loads in EX/MEM have no result yet, so only ALU results forward.
  // The register file writes at the edge, so wb must bypass it.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      a,
    input logic [XLEN-1:0] rf
  );
    if (a == 5'd0)
      fwd = '0;
    else if (mem_valid && mem_rd_we && !mem_is_load
             && mem_rd_addr == a)
      fwd = mem_result;
    else if (wb_we && wb_rd_addr == a)
      fwd = wb_data;
    else
      fwd = rf;
  endfunction

  // A source waits on a load held here or sitting in EX/MEM.
  function automatic logic ld_hit(input logic [4:0] a);
    ld_hit =
      (out_valid && out_is_load && out_rd_we
       && out_rd_addr == a) ||
      (mem_valid && mem_is_load && mem_rd_we
       && mem_rd_addr == a);
  endfunction

  assign rs1_val = fwd(in_rs1_addr, rf_rs1_data);
  assign rs2_val = fwd(in_rs2_addr, rf_rs2_data);

  assign m1 = in_valid && in_rs1_addr != 5'd0;
  assign m2 = in_valid && in_rs2_addr != 5'd0;

  assign hazard = (m1 && ld_hit(in_rs1_addr))
               || (m2 && ld_hit(in_rs2_addr));

  assign in_ready = !reset && !flush && !hazard
                 && (!out_valid || out_ready);

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd_addr <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
      stall_count <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_imm     <= in_imm;
        out_rs1_val <= rs1_val;
        out_rs2_val <= rs2_val;
        out_rd_addr <= in_rd_addr;
        out_rd_we   <= in_rd_we;
        out_is_load <= in_is_load;
        out_ctrl    <= in_ctrl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard && !flush && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding table,
// load-use stall, backpressure, flush and reset sequences.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_rd_we, in_is_load;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        mem_valid, mem_rd_we, mem_is_load;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we, out_is_load;
  logic [15:0] out_ctrl;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .in_ctrl(in_ctrl),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_valid(mem_valid), .mem_rd_we(mem_rd_we),
    .mem_is_load(mem_is_load), .mem_rd_addr(mem_rd_addr),
    .mem_result(mem_result),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .out_ctrl(out_ctrl),
    .stall_count(stall_count)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic        mv, mwe, mld;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rd_we = 0; in_is_load = 0; in_ctrl = 0;
    rf_rs1_data = 0; rf_rs2_data = 0;
    mem_valid = 0; mem_rd_we = 0; mem_is_load = 0;
    mem_rd_addr = 0; mem_result = 0;
    wb_we = 0; wb_rd_addr = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic instr(input logic [31:0] pc,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [4:0] rd,
                       input logic ld);
    in_valid = 1; in_pc = pc; in_imm = pc + 1;
    in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rd_addr = rd; in_rd_we = 1; in_is_load = ld;
    in_ctrl = pc[15:0];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    tv[0] = '{5'd5, 5'd6, 32'h11, 32'h66, 1'b1, 1'b1, 1'b0,
              5'd5, 32'h22, 1'b1, 5'd5, 32'h33, 32'h22, 32'h66};
    tv[1] = '{5'd5, 5'd6, 32'h11, 32'h66, 1'b0, 1'b1, 1'b0,
              5'd5, 32'h22, 1'b1, 5'd5, 32'h33, 32'h33, 32'h66};
    tv[2] = '{5'd5, 5'd6, 32'h11, 32'h66, 1'b0, 1'b1, 1'b0,
              5'd5, 32'h22, 1'b0, 5'd5, 32'h33, 32'h11, 32'h66};
    tv[3] = '{5'd0, 5'd0, 32'h1234, 32'h5678, 1'b1, 1'b1, 1'b0,
              5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h0, 32'h0};
    tv[4] = '{5'd5, 5'd5, 32'h11, 32'h11, 1'b1, 1'b0, 1'b0,
              5'd5, 32'h22, 1'b0, 5'd5, 32'h33, 32'h11, 32'h11};
    tv[5] = '{5'd3, 5'd9, 32'h3, 32'h9, 1'b1, 1'b1, 1'b0,
              5'd9, 32'h99, 1'b1, 5'd3, 32'h333, 32'h333, 32'h99};
    tv[6] = '{5'd1, 5'd2, 32'hA, 32'hB, 1'b1, 1'b1, 1'b1,
              5'd12, 32'hCC, 1'b1, 5'd13, 32'hDD, 32'hA, 32'hB};
    tv[7] = '{5'd4, 5'd4, 32'h44, 32'h44, 1'b0, 1'b0, 1'b0,
              5'd0, 32'h0, 1'b1, 5'd4, 32'h4444, 32'h4444, 32'h4444};
    tv[8] = '{5'd8, 5'd10, 32'h80, 32'hA0, 1'b1, 1'b1, 1'b0,
              5'd10, 32'h22, 1'b1, 5'd10, 32'h33, 32'h80, 32'h22};

    idle();
    reset = 1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);

    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle();
      instr(32'h1000 + 32'(i) * 4, tv[i].rs1, tv[i].rs2,
            5'(i + 1), 1'b0);
      rf_rs1_data = tv[i].rf1; rf_rs2_data = tv[i].rf2;
      mem_valid = tv[i].mv; mem_rd_we = tv[i].mwe;
      mem_is_load = tv[i].mld; mem_rd_addr = tv[i].mrd;
      mem_result = tv[i].mres;
      wb_we = tv[i].wwe; wb_rd_addr = tv[i].wrd;
      wb_data = tv[i].wdat;
      #1;
      chk($sformatf("v%0d_in_ready", i),
          {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d_rf_addr2", i),
          {27'd0, rf_rs2_addr}, {27'd0, tv[i].rs2});
      tick();
      chk($sformatf("v%0d_valid", i),
          {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_rs1", i), out_rs1_val, tv[i].e1);
      chk($sformatf("v%0d_rs2", i), out_rs2_val, tv[i].e2);
      chk($sformatf("v%0d_pc", i), out_pc,
          32'h1000 + 32'(i) * 4);
      chk($sformatf("v%0d_imm", i), out_imm,
          32'h1001 + 32'(i) * 4);
      chk($sformatf("v%0d_rd", i), {27'd0, out_rd_addr},
          32'(i + 1));
    end

    // load-use: lw x7 then add rs2=x7
    @(negedge clk);
    idle();
    instr(32'h300, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    chk("lw_accept", {31'd0, out_is_load}, 32'd1);
    @(negedge clk);
    idle();
    instr(32'h304, 5'd0, 5'd7, 5'd8, 1'b0);
    #1;
    chk("lu_stall1_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble1", {31'd0, out_valid}, 32'd0);
    chk("lu_bubble1_pc", out_pc, 32'h300);
    chk("lu_stall1_cnt", {16'd0, stall_count}, 32'd1);
    @(negedge clk);
    mem_valid = 1; mem_is_load = 1; mem_rd_we = 1;
    mem_rd_addr = 5'd7; mem_result = 32'h5555;
    #1;
    chk("lu_stall2_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble2", {31'd0, out_valid}, 32'd0);
    chk("lu_stall2_cnt", {16'd0, stall_count}, 32'd2);
    @(negedge clk);
    mem_valid = 0; mem_is_load = 0; mem_rd_we = 0;
    wb_we = 1; wb_rd_addr = 5'd7; wb_data = 32'hBEEF;
    rf_rs2_data = 32'h7777;
    #1;
    chk("lu_resume_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_rs2_wb", out_rs2_val, 32'hBEEF);
    chk("lu_cnt_final", {16'd0, stall_count}, 32'd2);

    // backpressure: hold for 3 cycles
    @(negedge clk);
    idle();
    instr(32'h500, 5'd0, 5'd0, 5'd9, 1'b0);
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c),
          {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", c),
          {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_pc", c), out_pc, 32'h304);
      chk($sformatf("bp%0d_rs2", c), out_rs2_val, 32'hBEEF);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_pc", out_pc, 32'h500);

    // flush during load-use stall
    @(negedge clk);
    idle();
    instr(32'h600, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    @(negedge clk);
    idle();
    instr(32'h604, 5'd7, 5'd0, 5'd8, 1'b0);
    flush = 1; out_ready = 0;
    #1;
    chk("fl_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_pc_kept", out_pc, 32'h600);
    chk("fl_cnt", {16'd0, stall_count}, 32'd2);

    // build stall_count=9 with a held load, then reset
    @(negedge clk);
    idle();
    out_ready = 0;
    instr(32'h700, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    @(negedge clk);
    instr(32'h704, 5'd7, 5'd0, 5'd8, 1'b0);
    repeat (7) tick();
    chk("pre_rst_cnt", {16'd0, stall_count}, 32'd9);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_cnt", {16'd0, stall_count}, 32'd0);
    chk("post_rst_pc", out_pc, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
